// File: rtl/mini_alu_pkg.sv
// Shared constants for the mini ALU scheduler: data width, opcodes, FSM encoding.
package mini_alu_pkg;

  localparam int DW    = 16;
  localparam int CNT_W = 4;

  // Last multiply step index; the step counter runs down from here to zero.
  localparam logic [CNT_W-1:0] MUL_LAST = 4'd15;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADD  = 3'd1,
    ST_NEG  = 3'd2,
    ST_MUL  = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  // First execution state for an accepted opcode.
  function automatic state_e op_to_state(input logic [1:0] op);
    state_e st;
    case (op)
      OP_ADD:  st = ST_ADD;
      OP_SUB:  st = ST_NEG;
      OP_MUL:  st = ST_MUL;
      default: st = ST_RESP;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mini_ALU_16bit_ADD.sv
// 16-bit ripple-carry adder; the only arithmetic resource of the scheduler.
module mini_ALU_16bit_ADD
  import mini_alu_pkg::*;
(
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic          i_cin,
  output logic [DW-1:0] o_sum,
  output logic          o_cout
);

  logic [DW:0] w_c;

  // Bit-serial carry chain, one full adder per bit.
  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < DW; i++) begin
      o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]   = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_cout = w_c[DW];

endmodule

// File: rtl/mini_alu_16bit_sched.sv
// Two-requester ALU scheduler: round-robin grant, one operation in flight,
// ADD/SUB/MUL sequenced over a single shared ripple adder.
//
// state | meaning
// IDLE  | waiting for a request; ready offered to the granted requester
// ADD   | one adder pass: a + b (b already negated for SUB)
// NEG   | b <= ~b + 1 ahead of the ADD pass of a subtract
// MUL   | 16 shift-and-add steps, one multiplier bit per cycle
// RESP  | result presented, held until the consumer accepts it
module mini_alu_16bit_sched
  import mini_alu_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [1:0]    req0_op,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [1:0]    req1_op,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_result,
  output logic          rsp_ovf,
  output logic          busy
);

  state_e            r_state;
  state_e            w_next;
  logic              r_ptr;
  logic              r_id;
  logic [1:0]        r_op;
  logic [DW-1:0]     r_a;
  logic [DW-1:0]     r_b;
  logic [DW-1:0]     r_acc;
  logic              r_ovf;
  logic              r_lost;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [DW-1:0]     r_rsp_result;
  logic              r_rsp_ovf;

  logic              w_grant_vld;
  logic              w_grant_id;
  logic              w_hs;
  logic [1:0]        w_sel_op;
  logic [DW-1:0]     w_sel_a;
  logic [DW-1:0]     w_sel_b;
  logic [DW-1:0]     w_add_x;
  logic [DW-1:0]     w_add_y;
  logic              w_add_cin;
  logic [DW-1:0]     w_sum;
  logic              w_cout;

  mini_ALU_16bit_ADD u_add (
    .i_a    (w_add_x),
    .i_b    (w_add_y),
    .i_cin  (w_add_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Round-robin arbitration; the pointer only matters when both are valid.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant_vld = 1'b1;
      w_grant_id  = r_ptr;
    end else if (req0_valid) begin
      w_grant_vld = 1'b1;
      w_grant_id  = 1'b0;
    end else if (req1_valid) begin
      w_grant_vld = 1'b1;
      w_grant_id  = 1'b1;
    end
  end

  assign w_sel_op = w_grant_id ? req1_op : req0_op;
  assign w_sel_a  = w_grant_id ? req1_a  : req0_a;
  assign w_sel_b  = w_grant_id ? req1_b  : req0_b;

  // Next-state and ready decode; ready is also held low while in reset.
  always_comb begin
    w_next     = r_state;
    w_hs       = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_vld && rst_n) begin
          req0_ready = ~w_grant_id;
          req1_ready = w_grant_id;
          w_hs       = 1'b1;
          w_next     = op_to_state(w_sel_op);
        end
      end
      ST_ADD:  w_next = ST_RESP;
      ST_NEG:  w_next = ST_ADD;
      ST_MUL:  if (r_cnt == '0) w_next = ST_RESP;
      ST_RESP: if (r_rsp_valid && rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Adder operand mux: negate b in NEG, accumulate partial products in MUL.
  always_comb begin
    w_add_x   = r_a;
    w_add_y   = r_b;
    w_add_cin = 1'b0;
    case (r_state)
      ST_NEG: begin
        w_add_x   = ~r_b;
        w_add_y   = '0;
        w_add_cin = 1'b1;
      end
      ST_MUL: begin
        w_add_x = r_acc;
        w_add_y = r_b[0] ? r_a : '0;
      end
      default: ;
    endcase
  end

  // Operand capture and per-state datapath updates.
  // For SUB, r_ovf carries the NEG-pass carry (set only when b == 0) into the
  // ADD pass, so borrow = no carry from either pass, i.e. a < b.
  // For MUL, r_a holds a << i and r_lost remembers any set bit shifted out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= RR_INIT;
      r_id   <= 1'b0;
      r_op   <= OP_ADD;
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_ovf  <= 1'b0;
      r_lost <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_ptr  <= ~w_grant_id;
            r_id   <= w_grant_id;
            r_op   <= w_sel_op;
            r_a    <= w_sel_a;
            r_b    <= w_sel_b;
            r_acc  <= '0;
            r_ovf  <= (w_sel_op == OP_ILL);
            r_lost <= 1'b0;
            r_cnt  <= MUL_LAST;
          end
        end
        ST_NEG: begin
          r_b   <= w_sum;
          r_ovf <= w_cout;
        end
        ST_ADD: begin
          r_acc <= w_sum;
          r_ovf <= (r_op == OP_SUB) ? ~(w_cout | r_ovf) : w_cout;
        end
        ST_MUL: begin
          if (r_b[0]) begin
            r_acc <= w_sum;
            if (w_cout || r_lost) r_ovf <= 1'b1;
          end
          r_a    <= r_a << 1;
          r_lost <= r_lost | r_a[DW-1];
          r_b    <= r_b >> 1;
          r_cnt  <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Response registers: loaded on RESP entry, held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_ovf    <= 1'b0;
    end else if (r_state == ST_RESP) begin
      if (!r_rsp_valid) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_id     <= r_id;
        r_rsp_result <= r_acc;
        r_rsp_ovf    <= r_ovf;
      end else if (rsp_ready) begin
        r_rsp_valid  <= 1'b0;
      end
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_ovf    = r_rsp_ovf;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: doc/mini_alu_16bit_sched.md
MINI_ALU_16BIT_SCHED -- requirements
Module: mini_alu_16bit_sched

Interface
REQ-001 Parameter: RR_INIT, default 0, requester holding priority after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req0_valid  in  1  requester 0 has an operation pending.
REQ-005 req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-006 req0_op  in  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 illegal.
REQ-007 req0_a / req0_b  in  16 each  unsigned operands.
REQ-008 req1_valid, req1_ready, req1_op, req1_a, req1_b SHALL mirror the requester 0 ports.
REQ-009 rsp_valid  out  1  result available.
REQ-010 rsp_ready  in  1  consumer accepts result.
REQ-011 rsp_id  out  1  requester that issued the operation.
REQ-012 rsp_result  out  16  result, modulo 2^16.
REQ-013 rsp_ovf  out  1  ADD carry-out; SUB borrow; MUL product > 16'hFFFF; illegal op.
REQ-014 busy  out  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ADD, NEG, MUL, RESP; exactly one operation is in flight at a time.
REQ-016 In IDLE, a single valid requester SHALL be granted; if both are valid, the requester selected by the round-robin pointer SHALL be granted.
REQ-017 reqX_ready SHALL be high only in IDLE for the granted requester; a handshake is valid&ready on a rising edge.
REQ-018 On handshake, the block SHALL capture op, a, b and id; the pointer SHALL move to the other requester; the state SHALL become ADD (op 00), NEG (op 01), MUL (op 10) or RESP (op 11).
REQ-019 ADD: one cycle; result = a+b via the shared adder; ovf = carry-out; then RESP.
REQ-020 NEG: one cycle; the adder SHALL produce ~b+1 into b; then ADD; final ovf SHALL be 1 iff a < b (unsigned), not raw carry.
REQ-021 MUL: 16 cycles, bit i per cycle; if b[i]=1, acc = acc + (a<<i) through the adder; result = low 16 bits of a*b; ovf = 1 iff any adder carry occurred or any set bit of a was shifted out while b[i]=1.
REQ-022 Illegal op: rsp_result = 0, rsp_ovf = 1.
REQ-023 Latency, handshake edge to first rsp_valid edge: ADD 2, SUB 3, MUL 17, illegal 1 cycles.
REQ-024 In RESP, rsp_valid, rsp_result, rsp_id and rsp_ovf SHALL hold stable until rsp_valid&rsp_ready; the state then returns to IDLE; no new request is accepted in the same cycle.
REQ-025 rsp_valid SHALL be 0 in every state except RESP; the adder SHALL be the only arithmetic resource.

Reset
REQ-026 Asserting rst_n low SHALL asynchronously force: state IDLE, pointer RR_INIT, rsp_valid 0, rsp_result 0, rsp_id 0, rsp_ovf 0, busy 0, and both ready outputs 0.
REQ-027 Reset during any non-IDLE state SHALL abort the operation silently, with no response.

Structure
REQ-028 Shared package mini_alu_pkg SHALL hold the opcode constants, state encoding and the data width (16).
REQ-029 The block SHALL instantiate exactly one sub-module: the team's 16-bit ripple adder mini_ALU_16bit_ADD, with operand muxing done in the scheduler.

Verification
REQ-030 ADD 16'hFFFF + 16'h0001 from req0 -> rsp_result 16'h0000, rsp_ovf 1, rsp_id 0, rsp_valid at cycle 2.
REQ-031 SUB 16'h0005 - 16'h0007 -> 16'hFFFE, ovf 1; SUB 16'h1234 - 16'h1234 -> 16'h0000, ovf 0; SUB x - 0 -> x, ovf 0.
REQ-032 MUL 16'h00FF * 16'h0101 -> 16'hFFFF, ovf 0; MUL 16'h0100 * 16'h0100 -> 16'h0000, ovf 1; each at latency 17.
REQ-033 Both requesters held valid with RR_INIT=0 -> grant order 0,1,0,1 and rsp_id matches.
REQ-034 rsp_ready held low 5 cycles in RESP -> outputs stable, both ready outputs low, busy 1.
REQ-035 rst_n pulsed low at MUL cycle 8 -> immediate return to IDLE, no rsp_valid, next ADD behaves correctly.
